// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// slave is the cache view; master is the datapath/memory-controller view.
interface icache_direct_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport slave (
        input  imemREN, imemaddr, flush, iload, iwait,
        output imemload, ihit, iREN, iaddr, hit_count, miss_count
    );

    modport master (
        output imemREN, imemaddr, flush, iload, iwait,
        input  imemload, ihit, iREN, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block, read-only instruction cache.
// Hits are answered combinationally in IDLE; a miss fills one frame from memory.
module icache_direct #(
    parameter int unsigned NSETS = 16
) (
    input logic             CLK,
    input logic             RST,
    icache_direct_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NSETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, MISS} state_t;

    state_t            state;
    state_t            state_next;
    logic [NSETS-1:0]  valid;
    logic [TAG_W-1:0]  tags [NSETS];
    logic [31:0]       data [NSETS];
    logic [31:0]       miss_addr;
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              hit;
    logic              start_miss;
    logic              fill;
    logic              unused_addr_lsb;

    assign idx             = bus.imemaddr[IDX_W+1:2];
    assign tag             = bus.imemaddr[31:IDX_W+2];
    assign fill_idx        = miss_addr[IDX_W+1:2];
    assign fill_tag        = miss_addr[31:IDX_W+2];
    assign unused_addr_lsb = ^bus.imemaddr[1:0];

    // Lookup and miss sequencing; flush suppresses both hits and new misses.
    always_comb begin
        state_next = state;
        hit        = 1'b0;
        start_miss = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.flush && bus.imemREN) begin
                    if (valid[idx] && (tags[idx] == tag)) begin
                        hit = 1'b1;
                    end else begin
                        start_miss = 1'b1;
                        state_next = MISS;
                    end
                end
            end
            MISS: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (!bus.iwait) begin
                    fill       = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame array, latched miss address and statistics counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid     <= '0;
            miss_addr <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            for (int unsigned i = 0; i < NSETS; i++) begin
                tags[IDX_W'(i)] <= '0;
                data[IDX_W'(i)] <= '0;
            end
        end else begin
            if (bus.flush) begin
                valid <= '0;
            end else if (fill) begin
                valid[fill_idx] <= 1'b1;
                tags[fill_idx]  <= fill_tag;
                data[fill_idx]  <= bus.iload;
            end
            if (start_miss) begin
                miss_addr <= {bus.imemaddr[31:2], 2'b00};
                miss_cnt  <= miss_cnt + 32'd1;
            end
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
        end
    end

    assign bus.imemload   = data[idx];
    assign bus.ihit       = hit;
    assign bus.iREN       = (state == MISS);
    assign bus.iaddr      = (state == MISS) ? miss_addr : 32'd0;
    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;
endmodule

// File: tb/tb_icache_direct.sv
// Directed testbench for icache_direct: cold miss, hits, conflicts, redirect,
// flush and reset behaviour with hand-computed expectations.
module tb_icache_direct;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    icache_direct_if bus ();

    icache_direct #(.NSETS(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one full cycle: inputs change and checks happen after the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_fill(input logic [31:0] addr, input logic [31:0] word);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        bus.iwait    = 1'b0;
        bus.iload    = word;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imemREN = 1'b0; bus.imemaddr = '0; bus.flush = 1'b0;
        bus.iwait = 1'b1; bus.iload = '0;
        step();
        step();
        rst = 1'b0;
        bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
        #1;
        n_cmp++;
        if (bus.iREN !== 1'b0 || bus.iaddr !== 32'h0 || bus.ihit !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs got iREN=%b iaddr=%h ihit=%b want 0/0/0", bus.iREN, bus.iaddr, bus.ihit);
        end
        n_cmp++;
        if (bus.imemload !== 32'h0 || bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data got imemload=%h hits=%0d misses=%0d want 0/0/0", bus.imemload, bus.hit_count, bus.miss_count);
        end
        bus.imemREN = 1'b0;
    endtask

    task automatic test_cold_miss();
        bus.imemREN = 1'b1; bus.imemaddr = 32'h40; bus.iwait = 1'b1; bus.iload = 32'h8C220004;
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0) begin
            n_err++;
            $display("FAIL cold_detect got ihit=%b iREN=%b want 0/0", bus.ihit, bus.iREN);
        end
        step();
        for (int c = 0; c < 4; c++) begin
            bus.iwait = (c < 3);
            #1;
            n_cmp++;
            if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h40 || bus.ihit !== 1'b0) begin
                n_err++;
                $display("FAIL cold_miss_cycle%0d got iREN=%b iaddr=%h ihit=%b want 1/00000040/0", c, bus.iREN, bus.iaddr, bus.ihit);
            end
            step();
        end
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b1 || bus.imemload !== 32'h8C220004 || bus.iREN !== 1'b0) begin
            n_err++;
            $display("FAIL cold_return got ihit=%b imemload=%h iREN=%b want 1/8c220004/0", bus.ihit, bus.imemload, bus.iREN);
        end
        step();
        bus.imemREN = 1'b0;
        #1;
        n_cmp++;
        if (bus.hit_count !== 32'd1 || bus.miss_count !== 32'd1) begin
            n_err++;
            $display("FAIL cold_counts got hits=%0d misses=%0d want 1/1", bus.hit_count, bus.miss_count);
        end
    endtask

    task automatic test_warm_hit();
        bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b1 || bus.iREN !== 1'b0 || bus.imemload !== 32'h8C220004) begin
            n_err++;
            $display("FAIL warm_hit got ihit=%b iREN=%b imemload=%h want 1/0/8c220004", bus.ihit, bus.iREN, bus.imemload);
        end
        step();
        bus.imemREN = 1'b0;
        #1;
        n_cmp++;
        if (bus.hit_count !== 32'd2 || bus.miss_count !== 32'd1) begin
            n_err++;
            $display("FAIL warm_counts got hits=%0d misses=%0d want 2/1", bus.hit_count, bus.miss_count);
        end
    endtask

    task automatic test_conflict();
        bus.imemREN = 1'b1; bus.imemaddr = 32'h80; bus.iwait = 1'b0; bus.iload = 32'hAAAA0080;
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_80_lookup got ihit=%b want 0", bus.ihit);
        end
        step();
        #1;
        n_cmp++;
        if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h80) begin
            n_err++;
            $display("FAIL conflict_80_miss got iREN=%b iaddr=%h want 1/00000080", bus.iREN, bus.iaddr);
        end
        step();
        bus.imemaddr = 32'h40;
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b0 || bus.imemload !== 32'hAAAA0080) begin
            n_err++;
            $display("FAIL conflict_40_evicted got ihit=%b imemload=%h want 0/aaaa0080", bus.ihit, bus.imemload);
        end
        step();
        bus.iload = 32'h8C220004;
        #1;
        n_cmp++;
        if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h40 || bus.miss_count !== 32'd3) begin
            n_err++;
            $display("FAIL conflict_40_miss got iREN=%b iaddr=%h misses=%0d want 1/00000040/3", bus.iREN, bus.iaddr, bus.miss_count);
        end
        step();
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b1 || bus.imemload !== 32'h8C220004) begin
            n_err++;
            $display("FAIL conflict_40_refill got ihit=%b imemload=%h want 1/8c220004", bus.ihit, bus.imemload);
        end
        bus.imemREN = 1'b0;
        step();
    endtask

    task automatic test_redirect();
        bus.imemREN = 1'b1; bus.imemaddr = 32'h100; bus.iwait = 1'b0; bus.iload = 32'h11111111;
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b0) begin
            n_err++;
            $display("FAIL redirect_100_lookup got ihit=%b want 0", bus.ihit);
        end
        step();
        bus.imemaddr = 32'h200;
        #1;
        n_cmp++;
        if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h100 || bus.ihit !== 1'b0) begin
            n_err++;
            $display("FAIL redirect_return got iREN=%b iaddr=%h ihit=%b want 1/00000100/0", bus.iREN, bus.iaddr, bus.ihit);
        end
        step();
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0 || bus.imemload !== 32'h11111111) begin
            n_err++;
            $display("FAIL redirect_frame got ihit=%b iREN=%b imemload=%h want 0/0/11111111", bus.ihit, bus.iREN, bus.imemload);
        end
        step();
        bus.iload = 32'h22222222;
        #1;
        n_cmp++;
        if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h200) begin
            n_err++;
            $display("FAIL redirect_second_miss got iREN=%b iaddr=%h want 1/00000200", bus.iREN, bus.iaddr);
        end
        step();
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b1 || bus.imemload !== 32'h22222222) begin
            n_err++;
            $display("FAIL redirect_200_hit got ihit=%b imemload=%h want 1/22222222", bus.ihit, bus.imemload);
        end
        bus.imemaddr = 32'h100;
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b0) begin
            n_err++;
            $display("FAIL redirect_100_evicted got ihit=%b want 0", bus.ihit);
        end
        bus.imemREN = 1'b0;
        step();
    endtask

    task automatic test_flush();
        do_fill(32'h40, 32'h8C220004);
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b1) begin
            n_err++;
            $display("FAIL flush_prefill_hit got ihit=%b want 1", bus.ihit);
        end
        bus.flush = 1'b1;
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b0) begin
            n_err++;
            $display("FAIL flush_cycle_ihit got ihit=%b want 0", bus.ihit);
        end
        step();
        bus.flush = 1'b0;
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0) begin
            n_err++;
            $display("FAIL flush_after got ihit=%b iREN=%b want 0/0", bus.ihit, bus.iREN);
        end
        step();
        #1;
        n_cmp++;
        if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h40) begin
            n_err++;
            $display("FAIL flush_remiss got iREN=%b iaddr=%h want 1/00000040", bus.iREN, bus.iaddr);
        end
        bus.flush = 1'b1; bus.iwait = 1'b0; bus.iload = 32'h33333333;
        step();
        bus.flush = 1'b0; bus.imemREN = 1'b0;
        #1;
        n_cmp++;
        if (bus.iREN !== 1'b0 || bus.iaddr !== 32'h0) begin
            n_err++;
            $display("FAIL flush_in_miss_state got iREN=%b iaddr=%h want 0/00000000", bus.iREN, bus.iaddr);
        end
        bus.imemREN = 1'b1;
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b0) begin
            n_err++;
            $display("FAIL flush_in_miss_nofill got ihit=%b want 0", bus.ihit);
        end
        bus.iload = 32'h8C220004;
        step();
        step();
        bus.imemREN = 1'b0;
    endtask

    task automatic test_reset_mid_miss();
        bus.imemREN = 1'b1; bus.imemaddr = 32'h80; bus.iwait = 1'b1; bus.iload = 32'h55555555;
        step();
        #1;
        n_cmp++;
        if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h80) begin
            n_err++;
            $display("FAIL rstmiss_in_miss got iREN=%b iaddr=%h want 1/00000080", bus.iREN, bus.iaddr);
        end
        rst = 1'b1; bus.iwait = 1'b0;
        step();
        rst = 1'b0; bus.imemREN = 1'b0;
        #1;
        n_cmp++;
        if (bus.iREN !== 1'b0 || bus.iaddr !== 32'h0 || bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0) begin
            n_err++;
            $display("FAIL rstmiss_cleared got iREN=%b iaddr=%h hits=%0d misses=%0d want 0/0/0/0", bus.iREN, bus.iaddr, bus.hit_count, bus.miss_count);
        end
        bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0) begin
            n_err++;
            $display("FAIL rstmiss_frame_invalid got ihit=%b imemload=%h want 0/00000000", bus.ihit, bus.imemload);
        end
        bus.imemaddr = 32'h80; bus.iwait = 1'b1;
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b0) begin
            n_err++;
            $display("FAIL rstmiss_same_addr got ihit=%b want 0", bus.ihit);
        end
        step();
        bus.iwait = 1'b0; bus.iload = 32'h44444444;
        #1;
        n_cmp++;
        if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h80 || bus.miss_count !== 32'd1) begin
            n_err++;
            $display("FAIL rstmiss_refetch got iREN=%b iaddr=%h misses=%0d want 1/00000080/1", bus.iREN, bus.iaddr, bus.miss_count);
        end
        step();
        #1;
        n_cmp++;
        if (bus.ihit !== 1'b1 || bus.imemload !== 32'h44444444) begin
            n_err++;
            $display("FAIL rstmiss_refill got ihit=%b imemload=%h want 1/44444444", bus.ihit, bus.imemload);
        end
        bus.imemREN = 1'b0;
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.imemREN = 1'b0; bus.imemaddr = '0; bus.flush = 1'b0;
        bus.iwait = 1'b1; bus.iload = '0;
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_warm_hit();
        test_conflict();
        test_redirect();
        test_flush();
        test_reset_mid_miss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
